// File: rtl/bitcount_unit.sv
// Purpose: pipelined CLZ / CTZ / CPOP on a W-bit operand, with a 32-bit word variant.
// Latency: 2 cycles from an accepted input to out_valid; 1 op/cycle with out_ready high.
// Backpressure: valid/ready; a stalled output holds, and the input stalls when stage 1 cannot advance.
// Ports: clk, reset_n (async, active-low), flush (squashes everything in flight),
//   in_valid/in_ready/in_op/in_word/in_src/in_tag (request side),
//   out_valid/out_ready/out_result/out_tag (result side), busy (any stage occupied).
module bitcount_unit #(
  parameter int LG_W     = 6,
  parameter int LG_CHUNK = 4,
  parameter int TAG_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic                  in_word,
  input  logic [(1<<LG_W)-1:0]  in_src,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LG_W:0]         out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

  localparam int W   = 1 << LG_W;
  localparam int C   = 1 << LG_CHUNK;
  localparam int NC  = W / C;
  localparam int CW  = LG_CHUNK + 1;
  localparam int RW  = LG_W + 1;
  // Chunk that holds bit 31, and how many bits of that chunk sit above bit 31
  // (non-zero only when a chunk is wider than 32 bits).
  localparam int K31 = 31 >> LG_CHUNK;
  localparam int OFF = (K31 + 1) * C - 32;

  typedef enum logic [1:0] {
    OP_CLZ  = 2'd0,
    OP_CTZ  = 2'd1,
    OP_CPOP = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  function automatic logic [CW-1:0] f_lz(input logic [C-1:0] c);
    logic [CW-1:0] r;
    r = CW'(C);
    for (int i = 0; i < C; i++) begin
      if (c[i]) r = CW'(C - 1 - i);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] f_tz(input logic [C-1:0] c);
    logic [CW-1:0] r;
    r = CW'(C);
    for (int i = C - 1; i >= 0; i--) begin
      if (c[i]) r = CW'(i);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] f_pop(input logic [C-1:0] c);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < C; i++) begin
      r = r + CW'(c[i]);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- control
  logic s1_valid;
  logic s1_adv;
  logic accept;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;
  assign busy     = s1_valid || out_valid;

  // ------------------------------------------------- operand preprocessing
  logic          word_eff;
  logic [W-1:0]  eff_src;

  // The word variant is meaningless on a 32-bit datapath.
  assign word_eff = (W > 32) ? in_word : 1'b0;

  always_comb begin
    eff_src = '0;
    for (int i = 0; i < W; i++) begin
      eff_src[i] = in_src[i] & (!word_eff || (i < 32));
    end
  end

  // ------------------------------------------------ stage 1: chunk summaries
  logic [CW-1:0] c_lz  [NC];
  logic [CW-1:0] c_tz  [NC];
  logic [CW-1:0] c_pop [NC];
  logic [NC-1:0] c_zero;

  always_comb begin
    c_zero = '0;
    for (int k = 0; k < NC; k++) begin
      c_lz[k]   = f_lz(eff_src[k*C +: C]);
      c_tz[k]   = f_tz(eff_src[k*C +: C]);
      c_pop[k]  = f_pop(eff_src[k*C +: C]);
      c_zero[k] = ~|eff_src[k*C +: C];
    end
  end

  op_e            s1_op;
  logic           s1_word;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0]  s1_lz  [NC];
  logic [CW-1:0]  s1_tz  [NC];
  logic [CW-1:0]  s1_pop [NC];
  logic [NC-1:0]  s1_zero;

  // Stage 1 payload only needs to be meaningful while s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op   <= op_e'(in_op);
      s1_word <= word_eff;
      s1_tag  <= in_tag;
      s1_lz   <= c_lz;
      s1_tz   <= c_tz;
      s1_pop  <= c_pop;
      s1_zero <= c_zero;
    end
  end

  // ------------------------------------------------- stage 2: combine chunks
  logic [RW-1:0] s2_res;
  logic          done;

  always_comb begin
    s2_res = '0;
    done   = 1'b0;
    case (s1_op)
      OP_CLZ: begin
        // In word mode the scan starts at the chunk holding bit 31; chunk
        // counts are C when the chunk is empty, so summing them is exact.
        for (int k = NC - 1; k >= 0; k--) begin
          if (!done && (!s1_word || k <= K31)) begin
            s2_res = s2_res + RW'(s1_lz[k]);
            done   = !s1_zero[k];
          end
        end
        // Discount the zero bits above bit 31 inside that first chunk.
        if (s1_word) s2_res = s2_res - RW'(OFF);
      end
      OP_CTZ: begin
        for (int k = 0; k < NC; k++) begin
          if (!done && (!s1_word || k <= K31)) begin
            s2_res = s2_res + RW'(s1_tz[k]);
            done   = !s1_zero[k];
          end
        end
        // A zero word scans past bit 31 only when chunks exceed 32 bits.
        if (s1_word && (s2_res > RW'(32))) s2_res = RW'(32);
      end
      OP_CPOP: begin
        // Bits above 31 were already cleared in word mode.
        for (int k = 0; k < NC; k++) begin
          s2_res = s2_res + RW'(s1_pop[k]);
        end
      end
      default: s2_res = '0;
    endcase
  end

  // ------------------------------------------------------- valids and output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          s1_valid <= 1'b1;
        end else if (s1_adv) begin
          s1_valid <= 1'b0;
        end
        if (s1_adv) out_valid <= s1_valid;
      end
      // Output payload only moves when the output register is free, so it
      // holds while out_valid && !out_ready.
      if (s1_adv && s1_valid) begin
        out_result <= s2_res;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule
